ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Synchronous request/response front end for the single-port asynchronous RAM (16 x 8, `we_in`/`enable_in`/`addr_in`, bidirectional `data`). Sits directly upstream of the RAM and owns the shared data bus. It converts a valid/ready request stream into legal RAM write and read cycles, inserts bus turnaround, and returns registered read data. After reset it optionally clears every location.

## Interface
- `ADDR_W`, 4: RAM address width; depth = 2**ADDR_W.
- `DATA_W`, 8: RAM data width.
- `CLEAR_EN`, 1: 1 = sweep-clear RAM after reset; 0 = go straight to IDLE.
- `CLEAR_VAL`, 8'h00: value written to every location during the clear sweep.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_in`  in  1  request present.
- `req_wr_in`  in  1  1 = write, 0 = read; sampled with `req_valid_in`.
- `req_addr_in`  in  ADDR_W  request address.
- `req_wdata_in`  in  DATA_W  write data.
- `req_ready_out`  out  1  controller can accept a request this cycle.
- `rsp_valid_out`  out  1  one-cycle pulse; `rsp_rdata_out` is valid.
- `rsp_rdata_out`  out  DATA_W  read data, held until the next read response.
- `init_done_out`  out  1  clear sweep finished; stays high until reset.
- `ram_we_out`  out  1  drives RAM `we_in`.
- `ram_enable_out`  out  1  drives RAM `enable_in`.
- `ram_addr_out`  out  ADDR_W  drives RAM `addr_in`.
- `ram_data`  inout  DATA_W  shared RAM data bus.

## Operation
- States: CLEAR, IDLE, WRITE, READ.
- Reset: state = CLEAR if `CLEAR_EN`, else IDLE. Clear counter = 0. `ram_addr_out` = 0. `rsp_rdata_out` = 0. `rsp_valid_out` = 0. `init_done_out` = !CLEAR_EN.
- CLEAR:
  - `ram_we_out`=1, `ram_enable_out`=0, `ram_addr_out`=counter, bus drives `CLEAR_VAL`.
  - Counter increments each cycle.
  - At counter = depth-1, next state is IDLE and `init_done_out` sets. Exactly `depth` cycles.
  - `req_ready_out`=0.
- IDLE:
  - `ram_we_out`=0, `ram_enable_out`=0, bus high-Z, `req_ready_out`=1.
  - On `req_valid_in && req_ready_out`: latch addr/wdata, go to WRITE if `req_wr_in`, else READ.
- WRITE:
  - `ram_we_out`=1, `ram_enable_out`=0, latched addr on `ram_addr_out`, latched wdata on bus.
  - One cycle, then IDLE.
- READ:
  - `ram_we_out`=0, `ram_enable_out`=1, bus high-Z (RAM drives).
  - At end of cycle, capture `ram_data` into `rsp_rdata_out` and set `rsp_valid_out` for the next cycle only.
  - One cycle, then IDLE.
- Bus rule: the controller drives `ram_data` only in CLEAR or WRITE. `ram_we_out` and `ram_enable_out` are never both 1.
- `req_ready_out` is high only in IDLE. Requests presented outside IDLE are ignored; the requester holds them.
- RAM-side outputs decode only from the state register and latched fields, never from request inputs combinationally.

## Timing
- Handshake occurs at edge T. The WRITE or READ cycle spans T to T+1. The controller is back in IDLE after T+1, so sustained throughput is 1 request per 2 cycles.
- The IDLE cycle between operations is the mandatory bus turnaround. No back-to-back RAM cycles outside CLEAR.
- Read latency: `rsp_valid_out` is high in cycle T+1..T+2, i.e. 2 edges after acceptance. It coincides with the next IDLE, where a new request may be accepted.
- Write issued immediately before a read of the same address: the read returns the new data, because the write completes before the turnaround.
- Reset mid-operation (any state): next edge forces reset values.
  - Any in-flight write is abandoned.
  - A pending `rsp_valid_out` is cancelled.
  - The clear sweep restarts at address 0.
- Address wrap: the clear counter is ADDR_W+1 bits wide, or terminates on compare, so it never wraps into a second sweep.

## Test plan
- Reset then clear (`CLEAR_VAL`=8'hA5):
  - `ram_we_out`=1 for exactly 16 cycles with addresses 0..15.
  - `init_done_out` rises on the 16th edge.
  - Reading addresses 0, 7 and 15 then returns 8'hA5.
- Write then read: write addr 4'h3 = 8'h5C, then read 4'h3.
  - `rsp_valid_out` pulses once, 2 edges after the read handshake, with `rsp_rdata_out`=8'h5C.
  - `ram_we_out` and `ram_enable_out` are never both high.
- Fill/dump: write addr i = 8'hF0^i for i=0..15 with `req_valid_in` held high.
  - `req_ready_out` toggles 1,0,1,0.
  - Reading 15 down to 0 returns 8'hFF..8'hF0.
- Bus turnaround:
  - A write followed immediately by a read shows one IDLE cycle with `ram_data` = Z and both enables low.
  - There is no X on `ram_data` at any time.
- Request during CLEAR: `req_valid_in`=1 from reset.
  - No handshake before `init_done_out`.
  - The request is accepted on the first IDLE cycle.
- Reset mid-read: assert `reset` in the READ cycle.
  - `rsp_valid_out` stays 0, `rsp_rdata_out`=0, state=CLEAR at addr 0.
  - The sweep completes normally after `reset` deasserts.

Source files
------------

// File: rtl/ram_ctrl.sv
// Valid/ready front end for a 16x8-style asynchronous single-port RAM: issues write/read
// cycles with a mandatory idle turnaround, returns registered read data, optional clear sweep.
module ram_ctrl #(
    parameter int unsigned              ADDR_W    = 4,
    parameter int unsigned              DATA_W    = 8,
    parameter bit                       CLEAR_EN  = 1'b1,
    parameter logic [DATA_W-1:0]        CLEAR_VAL = 8'h00
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_in,
    input  logic                req_wr_in,
    input  logic [ADDR_W-1:0]   req_addr_in,
    input  logic [DATA_W-1:0]   req_wdata_in,
    output logic                req_ready_out,
    output logic                rsp_valid_out,
    output logic [DATA_W-1:0]   rsp_rdata_out,
    output logic                init_done_out,
    output logic                ram_we_out,
    output logic                ram_enable_out,
    output logic [ADDR_W-1:0]   ram_addr_out,
    inout  wire  [DATA_W-1:0]   ram_data
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   bus_q;
    logic                drive_q;

    // Every RAM-side signal is a register updated together with the state, so the
    // pins depend only on the state register and latched request fields.
    assign ram_data = drive_q ? bus_q : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_EN) state <= CLEAR;
            else          state <= IDLE;
            cnt            <= '0;
            ram_addr_out   <= '0;
            rsp_rdata_out  <= '0;
            rsp_valid_out  <= 1'b0;
            init_done_out  <= !CLEAR_EN;
            req_ready_out  <= !CLEAR_EN;
            bus_q          <= CLEAR_VAL;
            drive_q        <= CLEAR_EN;
            ram_we_out     <= CLEAR_EN;
            ram_enable_out <= 1'b0;
        end else begin
            rsp_valid_out <= 1'b0;
            case (state)
                CLEAR: begin
                    // Terminates on compare, so the sweep never wraps into a second pass.
                    if (cnt == LAST) begin
                        state         <= IDLE;
                        init_done_out <= 1'b1;
                        req_ready_out <= 1'b1;
                        ram_we_out    <= 1'b0;
                        drive_q       <= 1'b0;
                    end else begin
                        cnt          <= cnt + 1'b1;
                        ram_addr_out <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid_in && req_ready_out) begin
                        req_ready_out <= 1'b0;
                        ram_addr_out  <= req_addr_in;
                        bus_q         <= req_wdata_in;
                        if (req_wr_in) begin
                            state      <= WRITE;
                            ram_we_out <= 1'b1;
                            drive_q    <= 1'b1;
                        end else begin
                            state          <= READ;
                            ram_enable_out <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state         <= IDLE;
                    ram_we_out    <= 1'b0;
                    drive_q       <= 1'b0;
                    req_ready_out <= 1'b1;
                end
                READ: begin
                    state          <= IDLE;
                    ram_enable_out <= 1'b0;
                    req_ready_out  <= 1'b1;
                    rsp_rdata_out  <= ram_data;
                    rsp_valid_out  <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    ram_we_out     <= 1'b0;
                    ram_enable_out <= 1'b0;
                    drive_q        <= 1'b0;
                    req_ready_out  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural asynchronous RAM on the shared bus.
module tb_ram_ctrl;

    localparam logic [7:0] CV = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid_in = 1'b0;
    logic       req_wr_in = 1'b0;
    logic [3:0] req_addr_in = '0;
    logic [7:0] req_wdata_in = '0;
    logic       req_ready_out, rsp_valid_out, init_done_out, ram_we_out, ram_enable_out;
    logic [7:0] rsp_rdata_out;
    logic [3:0] ram_addr_out;
    wire  [7:0] ram_data;

    logic [7:0] mem [16];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t dump[$];

    always #5 clock = ~clock;

    ram_ctrl #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .CLEAR_EN (1'b1),
        .CLEAR_VAL(CV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid_in  (req_valid_in),
        .req_wr_in     (req_wr_in),
        .req_addr_in   (req_addr_in),
        .req_wdata_in  (req_wdata_in),
        .req_ready_out (req_ready_out),
        .rsp_valid_out (rsp_valid_out),
        .rsp_rdata_out (rsp_rdata_out),
        .init_done_out (init_done_out),
        .ram_we_out    (ram_we_out),
        .ram_enable_out(ram_enable_out),
        .ram_addr_out  (ram_addr_out),
        .ram_data      (ram_data)
    );

    // RAM model: drives the bus while enabled, stores the bus value mid-cycle while written.
    assign ram_data = (ram_enable_out && !ram_we_out) ? mem[ram_addr_out] : 'z;
    always @(negedge clock) if (ram_we_out) mem[ram_addr_out] <= ram_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) chk("we_en_excl", {31'b0, ram_we_out & ram_enable_out}, 32'd0);

    task automatic sweep_check();
        for (int i = 0; i < 16; i++) begin
            chk("clr_we", ram_we_out, 1);
            chk("clr_en", ram_enable_out, 0);
            chk("clr_addr", ram_addr_out, i);
            chk("clr_data", ram_data, CV);
            chk("clr_done", init_done_out, 0);
            chk("clr_ready", req_ready_out, 0);
            @(posedge clock); #1;
        end
        chk("init_done", init_done_out, 1);
        chk("idle_ready", req_ready_out, 1);
        chk("idle_we", ram_we_out, 0);
        chk("idle_en", ram_enable_out, 0);
    endtask

    task automatic do_req(input vec_t v);
        int unsigned n = 0;
        while (!req_ready_out && n < 64) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_wait", req_ready_out, 1);
        req_valid_in = 1'b1;
        req_wr_in    = v.wr;
        req_addr_in  = v.addr;
        req_wdata_in = v.wdata;
        @(posedge clock); #1;
        req_valid_in = 1'b0;
        chk("op_addr", ram_addr_out, v.addr);
        chk("op_ready", req_ready_out, 0);
        chk("rsp_pulse", rsp_valid_out, 0);
        if (v.wr) begin
            chk("wr_we", ram_we_out, 1);
            chk("wr_en", ram_enable_out, 0);
            chk("wr_data", ram_data, v.wdata);
        end else begin
            chk("rd_we", ram_we_out, 0);
            chk("rd_en", ram_enable_out, 1);
        end
        @(posedge clock); #1;
        chk("ta_we", ram_we_out, 0);
        chk("ta_en", ram_enable_out, 0);
        chk("ta_ready", req_ready_out, 1);
        chk("rsp_valid", rsp_valid_out, !v.wr);
        if (!v.wr) chk("rsp_rdata", rsp_rdata_out, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{1'b0, 4'd0,  8'h00, CV});
        vecs.push_back('{1'b0, 4'd7,  8'h00, CV});
        vecs.push_back('{1'b0, 4'd15, 8'h00, CV});
        vecs.push_back('{1'b1, 4'd3,  8'h5C, 8'h00});
        vecs.push_back('{1'b0, 4'd3,  8'h00, 8'h5C});
        vecs.push_back('{1'b1, 4'd5,  8'h3C, 8'h00});
        vecs.push_back('{1'b0, 4'd5,  8'h00, 8'h3C});
        vecs.push_back('{1'b0, 4'd4,  8'h00, CV});
        for (int i = 15; i >= 0; i--)
            dump.push_back('{1'b0, 4'(i), 8'h00, 8'hF0 ^ 8'(i)});

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rsp_valid", rsp_valid_out, 0);
        chk("rst_rdata", rsp_rdata_out, 0);
        chk("rst_init_done", init_done_out, 0);
        chk("rst_addr", ram_addr_out, 0);
        chk("rst_ready", req_ready_out, 0);
        reset = 1'b0;
        sweep_check();

        foreach (vecs[k]) do_req(vecs[k]);

        // Fill with valid held high: ready alternates 1,0 while each write is taken.
        for (int i = 0; i < 16; i++) begin
            chk("fill_ready1", req_ready_out, 1);
            req_valid_in = 1'b1;
            req_wr_in    = 1'b1;
            req_addr_in  = 4'(i);
            req_wdata_in = 8'hF0 ^ 8'(i);
            @(posedge clock); #1;
            chk("fill_ready0", req_ready_out, 0);
            chk("fill_addr", ram_addr_out, i);
            chk("fill_data", ram_data, 8'hF0 ^ 8'(i));
            @(posedge clock); #1;
        end
        req_valid_in = 1'b0;
        foreach (dump[k]) do_req(dump[k]);

        // Request held from reset through the clear sweep.
        reset        = 1'b1;
        req_valid_in = 1'b1;
        req_wr_in    = 1'b0;
        req_addr_in  = 4'd7;
        @(posedge clock); #1;
        reset = 1'b0;
        sweep_check();
        @(posedge clock); #1;
        req_valid_in = 1'b0;
        chk("pend_rd_en", ram_enable_out, 1);
        chk("pend_rd_addr", ram_addr_out, 7);
        @(posedge clock); #1;
        chk("pend_rsp_valid", rsp_valid_out, 1);
        chk("pend_rsp_rdata", rsp_rdata_out, CV);

        // Reset during the READ cycle.
        do_req('{1'b1, 4'd9, 8'h77, 8'h00});
        req_valid_in = 1'b1;
        req_wr_in    = 1'b0;
        req_addr_in  = 4'd9;
        @(posedge clock); #1;
        req_valid_in = 1'b0;
        chk("mid_rd_en", ram_enable_out, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rsp_valid", rsp_valid_out, 0);
        chk("mid_rdata", rsp_rdata_out, 0);
        chk("mid_addr", ram_addr_out, 0);
        chk("mid_we", ram_we_out, 1);
        chk("mid_init_done", init_done_out, 0);
        reset = 1'b0;
        sweep_check();
        do_req('{1'b0, 4'd9, 8'h00, CV});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
